// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port.
// Holds the funct3 size codes, RAM flag encodings, the FSM state type and
// small decode helpers used when a request is accepted.
package lsu_pkg;

  // RV32I funct3 size/sign codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // RAM interface flag encodings (only NONE and WORD are ever driven)
  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_WORD = 3'b001;
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_WORD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2
  } lsu_state_e;

  // Loads accept B/H/W/BU/HU, stores only B/H/W.
  function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // Halfwords need an even offset, words need offset 0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return (off != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  // Drop the low address bits that a misaligned access would otherwise use.
  function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return {off[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store port.
// load_val: selected lane(s) of word, sign- or zero-extended by funct3.
// merged_word: word with the addressed lane(s) replaced by store data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [3:0]  lane_sel;

  // Pick the addressed byte/halfword and extend it to 32 bits
  always_comb begin
    sel_byte = word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_val = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_val = {24'd0, sel_byte};
      F3_H:    load_val = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_val = {16'd0, sel_half};
      default: load_val = word;
    endcase
  end

  // Which byte lanes the store overwrites
  always_comb begin
    case (funct3)
      F3_B:    lane_sel = 4'b0001 << offset;
      F3_H:    lane_sel = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  end

  // Per-lane merge: store bytes are right-justified in wdata, so a byte
  // store always sources wdata[7:0] and a halfword store wdata[15:0].
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_src;
      // Source byte for this lane if it is overwritten
      always_comb begin
        case (funct3)
          F3_B:    lane_src = wdata[7:0];
          F3_H:    lane_src = wdata[8*(gi%2) +: 8];
          default: lane_src = wdata[8*gi +: 8];
        endcase
      end
      assign merged_word[8*gi +: 8] = lane_sel[gi] ? lane_src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store requester for a word-indexed data RAM.
// Turns RV32I byte-addressed loads/stores into whole-word RAM accesses,
// extracting lanes for loads and doing read-modify-write for SB/SH.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are
// rejected with resp_err; without it the offending low bits are masked.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] write_ram_data,
  output logic [1:0]  write_ram_flag,
  output logic [2:0]  read_ram_flag,
  input  logic [31:0] ram_out
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  lsu_state_e       state_reg;
  logic             is_store_reg;
  logic [2:0]       funct3_reg;
  logic [1:0]       off_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [4:0]       rd_reg;
  logic             err_reg;
  logic [31:0]      merged_reg;

  logic             resp_valid_reg;
  logic [31:0]      resp_data_reg;
  logic [4:0]       resp_rd_reg;
  logic             resp_err_reg;

  logic             misalign_err;
  logic [1:0]       req_off;
  logic             req_err;
  logic             is_full_store;
  logic [31:0]      load_val;
  logic [31:0]      merged_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = is_misaligned(req_funct3, req_addr[1:0]);
  assign req_off      = req_addr[1:0];
`else
  assign misalign_err = 1'b0;
  assign req_off      = align_offset(req_funct3, req_addr[1:0]);
`endif

  // Range check uses the full word address so high address bits cannot alias
  assign req_err = funct3_illegal(req_is_store, req_funct3)
                 || (req_addr[31:2] >= DEPTH_W)
                 || misalign_err;

  assign is_full_store = is_store_reg && (funct3_reg == F3_W);
  assign req_ready     = (state_reg == ST_IDLE);

  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign resp_rd    = resp_rd_reg;
  assign resp_err   = resp_err_reg;

  lsu_lane_align u_align (
    .word        (ram_out),
    .offset      (off_reg),
    .funct3      (funct3_reg),
    .wdata       (wdata_reg),
    .load_val    (load_val),
    .merged_word (merged_word)
  );

  // Drive the RAM port from the current state; rst masks every flag so no
  // write can land on a reset edge
  always_comb begin
    ram_addr       = '0;
    write_ram_data = '0;
    write_ram_flag = WR_NONE;
    read_ram_flag  = RD_NONE;
    if (!rst) begin
      case (state_reg)
        ST_ACCESS: begin
          if (!err_reg) begin
            ram_addr = {{(32-IDX_W){1'b0}}, idx_reg};
            if (is_full_store) begin
              write_ram_flag = WR_WORD;
              write_ram_data = wdata_reg;
            end else begin
              read_ram_flag = RD_WORD;
            end
          end
        end
        ST_WRITE: begin
          ram_addr       = {{(32-IDX_W){1'b0}}, idx_reg};
          write_ram_flag = WR_WORD;
          write_ram_data = merged_reg;
        end
        default: ;
      endcase
    end
  end

  // Request latch, access sequencing and the registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      is_store_reg   <= 1'b0;
      funct3_reg     <= '0;
      off_reg        <= '0;
      idx_reg        <= '0;
      wdata_reg      <= '0;
      rd_reg         <= '0;
      err_reg        <= 1'b0;
      merged_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      resp_rd_reg    <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            is_store_reg <= req_is_store;
            funct3_reg   <= req_funct3;
            off_reg      <= req_off;
            idx_reg      <= req_addr[IDX_W+1:2];
            wdata_reg    <= req_wdata;
            rd_reg       <= req_rd;
            err_reg      <= req_err;
            state_reg    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (err_reg) begin
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= '0;
            resp_rd_reg    <= '0;
            resp_err_reg   <= 1'b1;
            state_reg      <= ST_IDLE;
          end else if (!is_store_reg) begin
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= load_val;
            resp_rd_reg    <= rd_reg;
            resp_err_reg   <= 1'b0;
            state_reg      <= ST_IDLE;
          end else if (is_full_store) begin
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= '0;
            resp_rd_reg    <= '0;
            resp_err_reg   <= 1'b0;
            state_reg      <= ST_IDLE;
          end else begin
            merged_reg <= merged_word;
            state_reg  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          resp_valid_reg <= 1'b1;
          resp_data_reg  <= '0;
          resp_rd_reg    <= '0;
          resp_err_reg   <= 1'b0;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: an attached RAM, a transaction-level
// reference model checked every cycle, directed cases with literal results,
// then a randomized request stream.
module tb_lsu_mem_port;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] write_ram_data;
  logic [1:0]  write_ram_flag;
  logic [2:0]  read_ram_flag;
  logic [31:0] ram_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  lsu_mem_port dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rd         (req_rd),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_rd        (resp_rd),
    .resp_err       (resp_err),
    .ram_addr       (ram_addr),
    .write_ram_data (write_ram_data),
    .write_ram_flag (write_ram_flag),
    .read_ram_flag  (read_ram_flag),
    .ram_out        (ram_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h8899AABB;
    return (32'(i + 1) * 32'h9E3779B9) ^ 32'h13579BDF;
  endfunction

  // Attached RAM: combinational read, write on the clock edge
  logic [31:0] ram [0:127];
  bit ram_loaded = 1'b0;
  assign ram_out = ram[ram_addr[6:0]];
  always @(posedge clk) begin
    if (rst && !ram_loaded) begin
      for (int i = 0; i < 128; i++) ram[i] = init_word(i);
      ram_loaded = 1'b1;
    end else if (write_ram_flag == 2'b01) begin
      ram[ram_addr[6:0]] = write_ram_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'd0: return {{24{s[7]}}, s[7:0]};
      3'd4: return {24'd0, s[7:0]};
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd5: return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    m = (f3 == 3'd0) ? (32'h000000FF << (8 * off)) : (32'h0000FFFF << (8 * off));
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  logic [31:0] gold [0:127];
  bit          gold_loaded = 1'b0;
  bit          pend = 1'b0;
  int          p_acc, p_resp, p_wr;
  bit          p_err, p_store;
  int          p_idx;
  logic [31:0] p_wword, p_data;
  logic [4:0]  p_rd;
  logic [31:0] last_data = '0;
  logic [4:0]  last_rd = '0;
  logic        last_err = 1'b0;

  // Compare process: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    logic        exp_ready, exp_valid;
    logic [2:0]  exp_rf;
    logic [1:0]  exp_wf;
    logic [31:0] exp_wd;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [1:0]  off;
    bit          illegal, mis, st;
    if (rst) begin
      if (!gold_loaded) begin
        for (int i = 0; i < 128; i++) gold[i] = init_word(i);
        gold_loaded = 1'b1;
      end
      chk("rst_wflag", 32'(write_ram_flag), 32'd0);
      chk("rst_rflag", 32'(read_ram_flag), 32'd0);
      pend = 1'b0;
      last_data = '0; last_rd = '0; last_err = 1'b0;
    end else begin
      exp_ready = !pend || (p_resp == cyc);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      exp_rf = 3'b000; exp_wf = 2'b00; exp_wd = '0;
      if (pend && !p_err && cyc == p_acc + 1) begin
        if (p_store && p_wr == cyc) begin exp_wf = 2'b01; exp_wd = p_wword; end
        else exp_rf = 3'b001;
      end
      if (pend && !p_err && p_store && p_wr == cyc && cyc == p_acc + 2) begin
        exp_wf = 2'b01; exp_wd = p_wword;
      end
      chk("read_flag", 32'(read_ram_flag), 32'(exp_rf));
      chk("write_flag", 32'(write_ram_flag), 32'(exp_wf));
      if (exp_rf != 3'b000 || exp_wf != 2'b00) chk("ram_addr", ram_addr, 32'(p_idx));
      if (exp_wf != 2'b00) chk("wr_data", write_ram_data, exp_wd);
      if (exp_wf != 2'b00) gold[p_idx] = exp_wd;
      exp_valid = pend && (p_resp == cyc);
      chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
      if (exp_valid) begin
        last_data = p_data; last_rd = p_rd; last_err = p_err;
        pend = 1'b0;
        $display("resp cyc=%0d data=%08h rd=%0d err=%0b", cyc, resp_data, resp_rd, resp_err);
      end
      chk("resp_data", resp_data, last_data);
      chk("resp_rd", 32'(resp_rd), 32'(last_rd));
      chk("resp_err", 32'(resp_err), 32'(last_err));
      if (req_valid && exp_ready) begin
        a  = req_addr;
        f3 = req_funct3;
        st = req_is_store;
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        off = a[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        p_err = illegal || ((a >> 2) >= 32'd128) || mis;
`else
        p_err = illegal || ((a >> 2) >= 32'd128);
        if (f3 == 3'd1 || f3 == 3'd5) off = off & 2'b10;
        if (f3 == 3'd2) off = 2'b00;
`endif
        pend = 1'b1; p_acc = cyc; p_store = st; p_wr = -1;
        p_idx = int'(a[8:2]); p_data = '0; p_rd = '0; p_wword = '0;
        p_resp = cyc + 2;
        if (!p_err) begin
          if (!st) begin
            p_data = ref_load(gold[p_idx], f3, off);
            p_rd = req_rd;
          end else if (f3 == 3'd2) begin
            p_wword = req_wdata; p_wr = cyc + 1;
          end else begin
            p_wword = ref_merge(gold[p_idx], f3, off, req_wdata);
            p_wr = cyc + 2; p_resp = cyc + 3;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entered and left at 1 time unit after a rising edge.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, output int acc);
    bit got;
    got = 1'b0; acc = -1;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = d; req_rd = rd;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; acc = cyc; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no ready expected ready within 12 cycles");
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
    end
  endtask

  initial begin
    int acc, acc2, gap;
    bit ok, st;
    logic [2:0] f3;
    logic [31:0] a, saved;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_ram_addr", ram_addr, 32'd0);
    @(posedge clk); #1;

    // LB 0x0B from RAM[2]=0x8899AABB
    issue(1'b0, 3'd0, 32'h0B, 32'd0, 5'd5, acc);
    wait_resp(ok);
    chk("lb_latency", 32'(cyc - acc), 32'd2);
    chk("lb_data", resp_data, 32'hFFFFFF88);
    chk("lb_rd", 32'(resp_rd), 32'd5);
    @(posedge clk); #1;
    issue(1'b0, 3'd5, 32'h0A, 32'd0, 5'd6, acc);
    wait_resp(ok);
    chk("lhu_data", resp_data, 32'h00008899);
    @(posedge clk); #1;
    issue(1'b0, 3'd1, 32'h08, 32'd0, 5'd7, acc);
    wait_resp(ok);
    chk("lh_data", resp_data, 32'hFFFFAABB);
    @(posedge clk); #1;

    // SB into lane 1 (read-modify-write)
    issue(1'b1, 3'd0, 32'h09, 32'h12345655, 5'd9, acc);
    wait_resp(ok);
    chk("sb_latency", 32'(cyc - acc), 32'd3);
    chk("sb_resp_data", resp_data, 32'd0);
    chk("sb_resp_rd", 32'(resp_rd), 32'd0);
    chk("sb_ram", ram[2], 32'h889955BB);
    @(posedge clk); #1;

    // Misaligned LW
    issue(1'b0, 3'd2, 32'h06, 32'd0, 5'd3, acc);
    wait_resp(ok);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(resp_err), 32'd1);
`else
    chk("lw_mis_err", 32'(resp_err), 32'd0);
    chk("lw_mis_rd", 32'(resp_rd), 32'd3);
`endif
    @(posedge clk); #1;

    // Out-of-range LW, then the same followed by a back-to-back SW
    issue(1'b0, 3'd2, 32'h200, 32'd0, 5'd4, acc);
    wait_resp(ok);
    chk("oor_err", 32'(resp_err), 32'd1);
    chk("oor_rd", 32'(resp_rd), 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 3'd2, 32'h200, 32'd0, 5'd4, acc);
    issue(1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 5'd1, acc2);
    chk("b2b_accept_gap", 32'(acc2 - acc), 32'd2);
    wait_resp(ok);
    chk("sw_latency", 32'(cyc - acc2), 32'd2);
    chk("sw_err", 32'(resp_err), 32'd0);
    chk("sw_ram", ram[4], 32'hCAFEF00D);
    @(posedge clk); #1;

    // Reset during the WRITE cycle of an SH
    saved = ram[3];
    issue(1'b1, 3'd1, 32'h0E, 32'h0000BEEF, 5'd2, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_wflag", 32'(write_ram_flag), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_ram", ram[3], saved);
    @(posedge clk); #1;

    // Randomized stream
    for (int k = 0; k < 300; k++) begin
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      st = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 3));
        if (f3 == 3'd3) f3 = 3'($urandom_range(4, 5));
      end
      case ($urandom_range(0, 15))
        0:       a = $urandom();
        1, 2:    a = 32'($urandom_range(500, 560));
        default: a = 32'($urandom_range(0, 31));
      endcase
      issue(st, f3, a, $urandom(), 5'($urandom_range(0, 31)), acc);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 128; i++) chk("final_ram", ram[i], gold[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
